acc_alu_seq: RTL and testbench

- Parametrised accumulator ALU for the SRP16 datapath; successor of the fixed 16-bit accumulator/flag ALU.
- Holds one WIDTH-bit accumulator and a 1-bit flag.
- Executes single-cycle arithmetic, logic and compare ops, plus iterative multi-cycle shift and multiply ops, with a busy/done handshake toward the control unit.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_seq_unit.sv | 89 ++++++++
 rtl/acc_alu_seq.sv | 107 ++++++++++
 tb/tb_acc_alu_seq.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encoding and sizing helpers for the accumulator ALU.
// Opcodes 15-31 are deliberately left undefined and decode as NOP.
package alu_pkg;
  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] OP_NOP    = 5'd0;
  localparam logic [OPCODE_W-1:0] OP_ADD    = 5'd1;
  localparam logic [OPCODE_W-1:0] OP_SUB    = 5'd2;
  localparam logic [OPCODE_W-1:0] OP_AND    = 5'd3;
  localparam logic [OPCODE_W-1:0] OP_OR     = 5'd4;
  localparam logic [OPCODE_W-1:0] OP_XOR    = 5'd5;
  localparam logic [OPCODE_W-1:0] OP_NOT    = 5'd6;
  localparam logic [OPCODE_W-1:0] OP_SHL    = 5'd7;
  localparam logic [OPCODE_W-1:0] OP_SHR    = 5'd8;
  localparam logic [OPCODE_W-1:0] OP_ASR    = 5'd9;
  localparam logic [OPCODE_W-1:0] OP_MUL    = 5'd10;
  localparam logic [OPCODE_W-1:0] OP_CMPLTS = 5'd11;
  localparam logic [OPCODE_W-1:0] OP_CMPLTU = 5'd12;
  localparam logic [OPCODE_W-1:0] OP_CMPEQ  = 5'd13;
  localparam logic [OPCODE_W-1:0] OP_CMPGTS = 5'd14;

  // One extra bit so the counter can hold WIDTH itself (MUL step count).
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction
endpackage

// File: rtl/alu_seq_unit.sv
// Iterative engine for SHL/SHR/ASR (one bit per cycle) and shift-add MUL.
// Exposes next-state values so the top can commit the result on the final step edge.
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [OPCODE_W-1:0] op,
  input  logic [WIDTH-1:0]    acc_in,
  input  logic [WIDTH-1:0]    operand_in,
  output logic                busy,
  output logic                last_step,
  output logic [WIDTH-1:0]    res_next,
  output logic                flag_next
);
  localparam int LG = $clog2(WIDTH);
  localparam int CW = cnt_width(WIDTH);

  logic                busy_reg;
  logic [CW-1:0]       cnt_reg;
  logic [OPCODE_W-1:0] op_reg;
  logic [WIDTH-1:0]    lo_reg;
  logic [WIDTH-1:0]    hi_reg;
  logic [WIDTH-1:0]    mc_reg;
  logic                sflag_reg;

  logic [WIDTH:0]      sum_w;
  logic [WIDTH-1:0]    hi_next;

  // For MUL, {hi,lo} starts as {0, multiplier} and ends holding the full product.
  always_comb begin
    sum_w     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, mc_reg} : '0);
    hi_next   = hi_reg;
    res_next  = lo_reg;
    flag_next = sflag_reg;
    case (op_reg)
      OP_SHL: begin
        res_next  = {lo_reg[WIDTH-2:0], 1'b0};
        flag_next = lo_reg[WIDTH-1];
      end
      OP_SHR: begin
        res_next  = {1'b0, lo_reg[WIDTH-1:1]};
        flag_next = lo_reg[0];
      end
      OP_ASR: begin
        res_next  = {lo_reg[WIDTH-1], lo_reg[WIDTH-1:1]};
        flag_next = lo_reg[0];
      end
      OP_MUL: begin
        hi_next   = sum_w[WIDTH:1];
        res_next  = {sum_w[0], lo_reg[WIDTH-1:1]};
        flag_next = |hi_next;
      end
      default: ;
    endcase
  end

  assign busy      = busy_reg;
  assign last_step = busy_reg && (cnt_reg == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_reg  <= 1'b0;
      cnt_reg   <= '0;
      op_reg    <= OP_NOP;
      lo_reg    <= '0;
      hi_reg    <= '0;
      mc_reg    <= '0;
      sflag_reg <= 1'b0;
    end else if (start) begin
      busy_reg  <= 1'b1;
      op_reg    <= op;
      lo_reg    <= (op == OP_MUL) ? operand_in : acc_in;
      mc_reg    <= acc_in;
      hi_reg    <= '0;
      sflag_reg <= 1'b0;
      cnt_reg   <= (op == OP_MUL) ? CW'(WIDTH) : {1'b0, operand_in[LG-1:0]};
    end else if (busy_reg) begin
      lo_reg    <= res_next;
      hi_reg    <= hi_next;
      sflag_reg <= flag_next;
      cnt_reg   <= cnt_reg - CW'(1);
      if (last_step) busy_reg <= 1'b0;
    end
  end
endmodule

// File: rtl/acc_alu_seq.sv
// Accumulator/flag ALU: single-cycle ops resolved here, shifts and MUL delegated
// to alu_seq_unit, with a busy/done handshake toward the control unit.
module acc_alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter bit MUL_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [WIDTH-1:0]    operand,
  input  logic                write,
  input  logic                exec,
  input  logic                read,
  output logic [WIDTH-1:0]    accout,
  output logic                flag,
  output logic                busy,
  output logic                done
);
  localparam int LG = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_reg;
  logic             flag_reg;
  logic             done_reg;

  logic             unit_busy;
  logic             unit_last;
  logic [WIDTH-1:0] unit_res;
  logic             unit_flag;

  logic             is_shift;
  logic             is_mul;
  logic             start;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [WIDTH-1:0] alu_acc;
  logic             alu_flag;

  // A zero shift amount never enters the engine; it completes like a NOP.
  assign is_shift = (opcode == OP_SHL) || (opcode == OP_SHR) || (opcode == OP_ASR);
  assign is_mul   = MUL_EN && (opcode == OP_MUL);
  assign start    = !unit_busy && !write && exec &&
                    ((is_shift && (|operand[LG-1:0])) || is_mul);

  always_comb begin
    add_w    = {1'b0, acc_reg} + {1'b0, operand};
    sub_w    = {1'b0, acc_reg} - {1'b0, operand};
    alu_acc  = acc_reg;
    alu_flag = flag_reg;
    case (opcode)
      OP_ADD:    begin alu_acc = add_w[WIDTH-1:0]; alu_flag = add_w[WIDTH]; end
      OP_SUB:    begin alu_acc = sub_w[WIDTH-1:0]; alu_flag = sub_w[WIDTH]; end
      OP_AND:    begin alu_acc = acc_reg & operand; alu_flag = ~|alu_acc; end
      OP_OR:     begin alu_acc = acc_reg | operand; alu_flag = ~|alu_acc; end
      OP_XOR:    begin alu_acc = acc_reg ^ operand; alu_flag = ~|alu_acc; end
      OP_NOT:    begin alu_acc = ~acc_reg;          alu_flag = ~|alu_acc; end
      OP_CMPLTS: alu_flag = $signed(acc_reg) < $signed(operand);
      OP_CMPLTU: alu_flag = acc_reg < operand;
      OP_CMPEQ:  alu_flag = acc_reg == operand;
      OP_CMPGTS: alu_flag = $signed(acc_reg) > $signed(operand);
      default: ;
    endcase
  end

  alu_seq_unit #(.WIDTH(WIDTH)) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (opcode),
    .acc_in     (acc_reg),
    .operand_in (operand),
    .busy       (unit_busy),
    .last_step  (unit_last),
    .res_next   (unit_res),
    .flag_next  (unit_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg  <= '0;
      flag_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (unit_busy) begin
        if (unit_last) begin
          acc_reg  <= unit_res;
          flag_reg <= unit_flag;
          done_reg <= 1'b1;
        end
      end else if (write) begin
        acc_reg <= operand;
      end else if (exec && !start) begin
        acc_reg  <= alu_acc;
        flag_reg <= alu_flag;
        done_reg <= 1'b1;
      end
    end
  end

  assign accout = read ? acc_reg : '0;
  assign flag   = flag_reg;
  assign busy   = unit_busy;
  assign done   = done_reg;
endmodule

// File: tb/tb_acc_alu_seq.sv
// Directed and random checks of acc_alu_seq (WIDTH=16) against an arithmetic model.
module tb_acc_alu_seq;
  import alu_pkg::*;
  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [4:0]    opcode = '0;
  logic [W-1:0]  operand = '0;
  logic          write = 1'b0;
  logic          exec = 1'b0;
  logic          read = 1'b1;
  logic [W-1:0]  accout;
  logic          flag, busy, done;

  int n_assert = 0;
  int n_fail = 0;
  logic [W-1:0] m_acc = '0;
  logic         m_flag = 1'b0;

  acc_alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .operand(operand), .write(write),
    .exec(exec), .read(read), .accout(accout), .flag(flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: result of one op from plain arithmetic; lat = busy cycles (0 = single-cycle).
  task automatic model(input logic [4:0] op, input logic [W-1:0] opnd, output int lat);
    int n;
    int s;
    longint unsigned p;
    lat = 0;
    n = int'(opnd[3:0]);
    case (op)
      OP_ADD: begin s = int'(m_acc) + int'(opnd); m_flag = (s > 65535); m_acc = m_acc + opnd; end
      OP_SUB: begin m_flag = (m_acc < opnd); m_acc = m_acc - opnd; end
      OP_AND: begin m_acc = m_acc & opnd; m_flag = (m_acc == 0); end
      OP_OR:  begin m_acc = m_acc | opnd; m_flag = (m_acc == 0); end
      OP_XOR: begin m_acc = m_acc ^ opnd; m_flag = (m_acc == 0); end
      OP_NOT: begin m_acc = ~m_acc; m_flag = (m_acc == 0); end
      OP_SHL: if (n != 0) begin lat = n; m_flag = m_acc[W-n]; m_acc = m_acc << n; end
      OP_SHR: if (n != 0) begin lat = n; m_flag = m_acc[n-1]; m_acc = m_acc >> n; end
      OP_ASR: if (n != 0) begin lat = n; m_flag = m_acc[n-1]; m_acc = $unsigned($signed(m_acc) >>> n); end
      OP_MUL: begin
        lat = W;
        p = longint'(m_acc) * longint'(opnd);
        m_acc = p[15:0];
        m_flag = (p[31:16] != 0);
      end
      OP_CMPLTS: m_flag = ($signed(m_acc) < $signed(opnd));
      OP_CMPLTU: m_flag = (m_acc < opnd);
      OP_CMPEQ:  m_flag = (m_acc == opnd);
      OP_CMPGTS: m_flag = ($signed(m_acc) > $signed(opnd));
      default: ;
    endcase
  endtask

  task automatic do_write(input logic [W-1:0] v);
    operand = v;
    write = 1'b1;
    tick();
    write = 1'b0;
    m_acc = v;
    chk("write_acc", accout, m_acc);
    chk("write_flag", flag, m_flag);
    chk("write_done", done, 0);
    $display("write 0x%04h -> acc 0x%04h", v, accout);
  endtask

  task automatic do_op(input logic [4:0] op, input logic [W-1:0] opnd, input bit disturb);
    int lat;
    model(op, opnd, lat);
    opcode = op;
    operand = opnd;
    exec = 1'b1;
    tick();
    exec = 1'b0;
    if (lat == 0) begin
      chk("single_done", done, 1);
      chk("single_busy", busy, 0);
    end else begin
      chk("start_busy", busy, 1);
      chk("start_done", done, 0);
      for (int k = 1; k < lat; k++) begin
        if (disturb) begin
          write = 1'b1;
          exec = 1'b1;
          operand = 16'($urandom);
          opcode = 5'($urandom_range(0, 14));
        end
        tick();
        chk("mid_busy", busy, 1);
        chk("mid_done", done, 0);
      end
      write = 1'b0;
      exec = 1'b0;
      tick();
      chk("end_busy", busy, 0);
      chk("end_done", done, 1);
    end
    chk("op_acc", accout, m_acc);
    chk("op_flag", flag, m_flag);
    tick();
    chk("done_drop", done, 0);
    chk("acc_hold", accout, m_acc);
    $display("op %0d opnd 0x%04h lat %0d -> acc 0x%04h flag %0b", op, opnd, lat, accout, flag);
  endtask

  initial begin
    #12;
    chk("rst_acc", accout, 0);
    chk("rst_flag", flag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    do_write(16'h7000);
    read = 1'b0;
    #1;
    chk("read_off", accout, 0);
    read = 1'b1;

    do_op(OP_CMPLTS, 16'h8000, 1'b0);
    do_op(OP_CMPLTU, 16'h8000, 1'b0);

    do_write(16'hFFFF);
    do_op(OP_ADD, 16'h0001, 1'b0);

    do_write(16'h1234);
    do_op(OP_SHL, 16'h0004, 1'b1);

    // write wins over exec in the same cycle
    operand = 16'h00AA;
    opcode = OP_NOT;
    write = 1'b1;
    exec = 1'b1;
    tick();
    write = 1'b0;
    exec = 1'b0;
    m_acc = 16'h00AA;
    chk("wr_exec_acc", accout, m_acc);
    chk("wr_exec_done", done, 0);
    $display("write+exec -> acc 0x%04h done %0b", accout, done);

    do_op(OP_SHR, 16'h0010, 1'b0);

    do_write(16'h0003);
    do_op(OP_MUL, 16'h0005, 1'b1);
    do_write(16'h0100);
    do_op(OP_MUL, 16'h0100, 1'b0);

    // asynchronous reset in the middle of a MUL
    do_write(16'h0003);
    opcode = OP_MUL;
    operand = 16'h0005;
    exec = 1'b1;
    tick();
    exec = 1'b0;
    repeat (6) tick();
    #2;
    rst_n = 1'b0;
    #1;
    m_acc = '0;
    m_flag = 1'b0;
    chk("mid_rst_acc", accout, 0);
    chk("mid_rst_flag", flag, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    $display("reset mid-MUL -> acc 0x%04h busy %0b", accout, busy);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_busy", busy, 0);
    do_write(16'h0002);
    do_op(OP_ADD, 16'h0003, 1'b0);

    repeat (40) begin
      if ($urandom_range(0, 3) == 0) do_write(16'($urandom));
      else do_op(5'($urandom_range(0, 31)), 16'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
